ds1302_cmd_sequencer: RTL and testbench
=======================================

DS1302_CMD_SEQUENCER -- requirements
Module: ds1302_cmd_sequencer

Interface
REQ-001 Parameter AUTO_WP, default 1: when 1, every write is wrapped in unprotect (reg 7 <= 8'h00) and protect (reg 7 <= 8'h80) transfers.
REQ-002 Parameter MAX_LEN, default 8: maximum registers per scan-read command; LEN_W = clog2(MAX_LEN+1).
REQ-003 Parameter TIMEOUT_CYC, default 4096: cycles func_start may stay nonzero without func_done before abort.
REQ-004 Reset and clock: one clock; reset is asynchronous and active-low; ports are clk and rst_n.
REQ-005 clk  in  1  system clock, all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cmd_valid  in  1  command request; cmd_ready  out  1  high only in IDLE; accept = valid & ready.
REQ-008 cmd_op  in  2  00 single read, 01 single write, 10 scan read, 11 reserved (error).
REQ-009 cmd_ram  in  1  0 clock/calendar space, 1 RAM space; cmd_reg  in  5  start register index.
REQ-010 cmd_len  in  LEN_W  scan length; cmd_wdata  in  8  write payload.
REQ-011 rd_valid  out  1  one-cycle pulse per read byte; rd_data  out  8; rd_index  out  5  register index of rd_data.
REQ-012 cmd_done  out  1  one-cycle completion pulse; cmd_err  out  1  status, valid with cmd_done, held until next accept.
REQ-013 func_start  out  2  10 write, 01 read, 00 idle, to byte-level function layer; func_done  in  1  transfer complete.
REQ-014 register_addr  out  8  {1'b1, ram, reg[4:0], rd}; write_data  out  8; read_data  in  8.

Function
REQ-015 FSM states: IDLE, UNPROT, XFER, GAP, PROT, DONE.
REQ-016 On accept, all cmd_* fields are latched; the next cycle enters UNPROT (write with AUTO_WP=1) or XFER, with func_start nonzero that cycle.
REQ-017 register_addr and write_data are stable whenever func_start is nonzero.
REQ-018 func_start is held until func_done is sampled high; func_start is 00 on the following cycle (GAP, one cycle) before any next transfer.
REQ-019 Read: on func_done, rd_data <= read_data and rd_index <= current index; rd_valid pulses on the next cycle.
REQ-020 Scan read: cmd_len 0 is treated as 1; cmd_len > MAX_LEN is clamped to MAX_LEN; index increments by 1 per byte.
REQ-021 Index 31 (burst address) is never driven: if cmd_reg = 31, go straight to DONE with cmd_err=1 and no transfer; if a scan would reach 31, stop after index 30 with cmd_err=1.
REQ-022 Write with AUTO_WP=1: UNPROT, GAP, XFER, GAP, PROT, DONE; a direct write to clock reg 7 (cmd_ram=0) is not wrapped.
REQ-023 Reads never issue protect transfers.
REQ-024 Timeout: counter clears on each new transfer; at TIMEOUT_CYC, func_start drops to 00 and the FSM goes to DONE with cmd_err=1, with no protect attempt.
REQ-025 cmd_op = 11 goes to DONE with cmd_err=1 and no transfer.
REQ-026 DONE lasts one cycle (cmd_done=1), then IDLE; cmd_valid in DONE is ignored.
REQ-027 A func_done seen while func_start = 00 is ignored.

Reset
REQ-028 Reset values: state IDLE, cmd_ready 1, func_start 00, register_addr 8'h00, write_data 8'h00.
REQ-029 Reset values: rd_valid 0, rd_data 8'h00, rd_index 0, cmd_done 0, cmd_err 0, timeout counter 0.
REQ-030 Reset asserted mid-command aborts immediately with no completion pulse.

Structure
REQ-031 Package ds1302_pkg holds the op codes, the FSM state encoding, WP_REG=7, WP_OFF=8'h00, WP_ON=8'h80 and the func_start codes.
REQ-032 The timeout counter is one sub-module, ds1302_wdog (clear, enable, expired), parameterised by TIMEOUT_CYC.

Verification
REQ-033 Single write of cmd_reg=2, wdata 8'h12, AUTO_WP=1 -> transfers 8'h8E/00, 8'h84/12, 8'h8E/80 in order, one cmd_done, cmd_err=0.
REQ-034 Scan read of cmd_reg=0, len 3 -> addresses 8'h81, 8'h83, 8'h85; three rd_valid pulses with rd_index 0,1,2 and data equal to the model's.
REQ-035 Scan from cmd_reg=29, len 4 -> reads 29 and 30 only, then cmd_done with cmd_err=1.
REQ-036 func_done held low -> func_start drops after exactly TIMEOUT_CYC cycles; cmd_done with cmd_err=1; the next command succeeds.
REQ-037 rst_n asserted during XFER -> all outputs at reset values asynchronously; cmd_ready=1 after release.
REQ-038 cmd_op=11 or cmd_reg=31 -> cmd_done two cycles after accept, cmd_err=1, func_start never nonzero.

Source files
------------

// File: rtl/ds1302_pkg.sv
// ds1302_pkg: shared encodings for the DS1302 command sequencer.
//   op_e      : command op codes carried on cmd_op
//   state_e   : sequencer FSM state encoding
//   WP_*      : write-protect register index and its two payloads
//   FUNC_*    : func_start codes toward the byte-level function layer
package ds1302_pkg;

   typedef enum logic [1:0] {
      OpRead  = 2'b00,
      OpWrite = 2'b01,
      OpScan  = 2'b10,
      OpRsvd  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StUnprot = 3'd1,
      StXfer   = 3'd2,
      StGap    = 3'd3,
      StProt   = 3'd4,
      StDone   = 3'd5
   } state_e;

   localparam logic [4:0] WP_REG    = 5'd7;
   localparam logic [7:0] WP_OFF    = 8'h00;
   localparam logic [7:0] WP_ON     = 8'h80;
   // Index 31 selects burst mode on the device and must never be addressed.
   localparam logic [4:0] BURST_REG = 5'd31;
   localparam logic [4:0] LAST_REG  = 5'd30;

   localparam logic [1:0] FUNC_IDLE  = 2'b00;
   localparam logic [1:0] FUNC_READ  = 2'b01;
   localparam logic [1:0] FUNC_WRITE = 2'b10;

   // Command byte: {1, ram/clock select, register index, read/write}.
   function automatic logic [7:0] ds_addr(input logic ram, input logic [4:0] reg_idx,
                                          input logic rd);
      return {1'b1, ram, reg_idx, rd};
   endfunction

endpackage

// File: rtl/ds1302_wdog.sv
// ds1302_wdog: transfer timeout counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : forces the count back to zero (priority over enable)
//   enable     : counts one per cycle while high
//   expired    : high in the TIMEOUT_CYC-th enabled cycle since the last clear
module ds1302_wdog #(
   parameter int unsigned TIMEOUT_CYC = 4096,
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable && (count_q != LAST)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/ds1302_cmd_sequencer.sv
// ds1302_cmd_sequencer: turns register-level commands into byte transfers.
//   cmd_*          : command handshake (valid/ready), op, space, start index, length, payload
//   rd_*           : one pulse per byte read, with its register index
//   cmd_done/err   : completion pulse and status held until the next accept
//   func_start/... : byte-level transfer request toward the function layer
module ds1302_cmd_sequencer
   import ds1302_pkg::*;
#(
   parameter int unsigned AUTO_WP     = 1,
   parameter int unsigned MAX_LEN     = 8,
   parameter int unsigned TIMEOUT_CYC = 4096,
   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic             cmd_ram,
   input  logic [4:0]       cmd_reg,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [7:0]       cmd_wdata,
   output logic             rd_valid,
   output logic [7:0]       rd_data,
   output logic [4:0]       rd_index,
   output logic             cmd_done,
   output logic             cmd_err,
   output logic [1:0]       func_start,
   input  logic             func_done,
   output logic [7:0]       register_addr,
   output logic [7:0]       write_data,
   input  logic [7:0]       read_data
);

   state_e           state_q, state_d;
   state_e           gap_next_q, gap_next_d;   // where the one-cycle GAP leads
   op_e              op_q, op_d;
   logic             ram_q, ram_d;
   logic [4:0]       idx_q, idx_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;             // bytes still to read, including current
   logic [7:0]       wdata_q, wdata_d;
   logic             err_q, err_d;
   logic             rd_valid_q, rd_fire;
   logic [7:0]       rd_data_q;
   logic [4:0]       rd_index_q;
   logic [LEN_W-1:0] eff_len;
   logic             wrap_new, wrap_cur, xfer_active, expired, is_rd;

   // A direct write to the clock-space WP register manages protection itself.
   assign wrap_new = (AUTO_WP != 0) && !(!cmd_ram && (cmd_reg == WP_REG));
   assign wrap_cur = (AUTO_WP != 0) && !(!ram_q && (idx_q == WP_REG));
   assign is_rd    = (op_q != OpWrite);

   always_comb begin
      if (cmd_len == '0) begin
         eff_len = LEN_W'(1);
      end else if (cmd_len > LEN_W'(MAX_LEN)) begin
         eff_len = LEN_W'(MAX_LEN);
      end else begin
         eff_len = cmd_len;
      end
   end

   assign xfer_active = (state_q == StUnprot) || (state_q == StXfer) || (state_q == StProt);

   ds1302_wdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!xfer_active),
      .enable  (xfer_active),
      .expired (expired)
   );

   always_comb begin
      state_d       = state_q;
      gap_next_d    = gap_next_q;
      op_d          = op_q;
      ram_d         = ram_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      wdata_d       = wdata_q;
      err_d         = err_q;
      func_start    = FUNC_IDLE;
      register_addr = 8'h00;
      write_data    = 8'h00;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               op_d    = op_e'(cmd_op);
               ram_d   = cmd_ram;
               idx_d   = cmd_reg;
               wdata_d = cmd_wdata;
               cnt_d   = (cmd_op == OpScan) ? eff_len : LEN_W'(1);
               err_d   = 1'b0;
               if ((cmd_op == OpRsvd) || (cmd_reg == BURST_REG)) begin
                  // Pass through GAP so no transfer is ever requested.
                  err_d      = 1'b1;
                  gap_next_d = StDone;
                  state_d    = StGap;
               end else if ((cmd_op == OpWrite) && wrap_new) begin
                  state_d = StUnprot;
               end else begin
                  state_d = StXfer;
               end
            end
         end
         StUnprot: begin
            func_start    = FUNC_WRITE;
            register_addr = ds_addr(1'b0, WP_REG, 1'b0);
            write_data    = WP_OFF;
            if (func_done) begin
               gap_next_d = StXfer;
               state_d    = StGap;
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = StDone;
            end
         end
         StXfer: begin
            func_start    = is_rd ? FUNC_READ : FUNC_WRITE;
            register_addr = ds_addr(ram_q, idx_q, is_rd);
            write_data    = is_rd ? 8'h00 : wdata_q;
            if (func_done) begin
               state_d = StGap;
               if (!is_rd) begin
                  gap_next_d = wrap_cur ? StProt : StDone;
               end else if (cnt_q <= LEN_W'(1)) begin
                  gap_next_d = StDone;
               end else if (idx_q == LAST_REG) begin
                  err_d      = 1'b1;
                  gap_next_d = StDone;
               end else begin
                  idx_d      = idx_q + 5'd1;
                  cnt_d      = cnt_q - LEN_W'(1);
                  gap_next_d = StXfer;
               end
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = StDone;
            end
         end
         StGap: begin
            state_d = gap_next_q;
         end
         StProt: begin
            func_start    = FUNC_WRITE;
            register_addr = ds_addr(1'b0, WP_REG, 1'b0);
            write_data    = WP_ON;
            if (func_done) begin
               state_d = StDone;
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign rd_fire = (state_q == StXfer) && is_rd && func_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         gap_next_q <= StIdle;
         op_q       <= OpRead;
         ram_q      <= 1'b0;
         idx_q      <= 5'd0;
         cnt_q      <= '0;
         wdata_q    <= 8'h00;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 8'h00;
         rd_index_q <= 5'd0;
      end else begin
         state_q    <= state_d;
         gap_next_q <= gap_next_d;
         op_q       <= op_d;
         ram_q      <= ram_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         rd_valid_q <= rd_fire;
         if (rd_fire) begin
            rd_data_q  <= read_data;
            rd_index_q <= idx_q;
         end
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign cmd_done  = (state_q == StDone);
   assign cmd_err   = err_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign rd_index  = rd_index_q;

endmodule

// File: tb/tb_ds1302_cmd_sequencer.sv
// tb_ds1302_cmd_sequencer: self-checking bench for ds1302_cmd_sequencer.
// A responder stands in for the byte-level function layer; a reference model
// derives the expected transfer list, read stream and status per command.
module tb_ds1302_cmd_sequencer;

   localparam int unsigned TB_TO = 64;

   typedef struct packed {
      logic [1:0] fs;
      logic [7:0] addr;
      logic [7:0] wd;
   } xfer_t;

   typedef struct packed {
      logic [4:0] idx;
      logic [7:0] data;
   } rd_t;

   typedef struct {
      logic [1:0] op;
      logic       ram;
      logic [4:0] r;
      logic [3:0] len;
      logic [7:0] wd;
      int         n_xfer;
      int         n_rd;
      bit         err;
   } vec_t;

   logic       clk, rst_n;
   logic       cmd_valid, cmd_ready, cmd_ram, rd_valid, cmd_done, cmd_err, func_done;
   logic [1:0] cmd_op, func_start;
   logic [4:0] cmd_reg, rd_index;
   logic [3:0] cmd_len;
   logic [7:0] cmd_wdata, rd_data, register_addr, write_data, read_data;

   ds1302_cmd_sequencer #(
      .AUTO_WP     (1),
      .MAX_LEN     (8),
      .TIMEOUT_CYC (TB_TO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_ram       (cmd_ram),
      .cmd_reg       (cmd_reg),
      .cmd_len       (cmd_len),
      .cmd_wdata     (cmd_wdata),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .rd_index      (rd_index),
      .cmd_done      (cmd_done),
      .cmd_err       (cmd_err),
      .func_start    (func_start),
      .func_done     (func_done),
      .register_addr (register_addr),
      .write_data    (write_data),
      .read_data     (read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   string       cur_tag  = "init";
   logic [7:0]  mem [64];
   xfer_t       xfer_q[$], exp_x[$];
   rd_t         rd_q[$], exp_r[$];
   bit          exp_err;
   bit          hang = 1'b0;
   int          spur_req = 0;
   int          done_cnt = 0;
   logic        done_err = 1'b0;
   int          gap_viol = 0;
   int          base_x, base_r, base_d, done_at;
   logic [1:0]  first_fs;
   logic [7:0]  first_addr, first_wd;
   vec_t        vecs [14];
   logic [1:0]  r_op;
   logic        r_ram;
   logic [4:0]  r_reg;
   logic [3:0]  r_len;
   logic [7:0]  r_wd;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s/%s: got %0h, expected %0h", cur_tag, name, got, exp);
   endtask

   // Function-layer responder: completes each transfer after 0..3 extra cycles.
   initial begin
      int lat;
      int spur_ack;
      lat      = 0;
      spur_ack = 0;
      func_done = 1'b0;
      read_data = 8'h00;
      forever begin
         @(negedge clk);
         if (func_done) begin
            func_done = 1'b0;
            if (func_start != 2'b00) gap_viol++;
         end else if (!hang && (func_start != 2'b00)) begin
            if (lat == 0) begin
               func_done = 1'b1;
               read_data = mem[register_addr[6:1]];
               xfer_q.push_back('{fs: func_start, addr: register_addr, wd: write_data});
               lat = $urandom_range(0, 3);
            end else begin
               lat--;
            end
         end else if (spur_req != spur_ack) begin
            func_done = 1'b1;
            spur_ack++;
         end
      end
   end

   // Output monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (cmd_done) begin
            done_cnt++;
            done_err = cmd_err;
         end
         if (rd_valid) rd_q.push_back('{idx: rd_index, data: rd_data});
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_watchdog: got no finish, expected finish");
      $fatal(1, "bench stalled");
   end

   // Reference model: expected transfers, reads and status of one command.
   task automatic build_model(input logic [1:0] op, input logic ram, input logic [4:0] r,
                              input logic [3:0] len, input logic [7:0] wd);
      int  n;
      int  idx;
      bit  wrap;
      exp_x.delete();
      exp_r.delete();
      exp_err = 1'b0;
      if ((op == 2'b11) || (r == 5'd31)) begin
         exp_err = 1'b1;
      end else if (op == 2'b01) begin
         wrap = !((ram == 1'b0) && (r == 5'd7));
         if (wrap) exp_x.push_back('{fs: 2'b10, addr: 8'h8E, wd: 8'h00});
         exp_x.push_back('{fs: 2'b10, addr: {1'b1, ram, r, 1'b0}, wd: wd});
         if (wrap) exp_x.push_back('{fs: 2'b10, addr: 8'h8E, wd: 8'h80});
      end else begin
         if (op == 2'b00 || len == 4'd0) n = 1;
         else if (len > 4'd8) n = 8;
         else n = int'(len);
         for (int k = 0; k < n; k++) begin
            idx = int'(r) + k;
            if (idx > 30) begin
               exp_err = 1'b1;
               break;
            end
            exp_x.push_back('{fs: 2'b01, addr: {1'b1, ram, 5'(idx), 1'b1}, wd: 8'h00});
            exp_r.push_back('{idx: 5'(idx), data: mem[{ram, 5'(idx)}]});
         end
      end
   endtask

   task automatic wait_ready();
      int w;
      w = 0;
      while (!cmd_ready && w < 50) begin
         @(negedge clk);
         #1;
         w++;
      end
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic ram, input logic [4:0] r,
                          input logic [3:0] len, input logic [7:0] wd);
      int w;
      wait_ready();
      base_x    = xfer_q.size();
      base_r    = rd_q.size();
      base_d    = done_cnt;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_ram   = ram;
      cmd_reg   = r;
      cmd_len   = len;
      cmd_wdata = wd;
      @(negedge clk);
      #1;
      cmd_valid  = 1'b0;
      first_fs   = func_start;
      first_addr = register_addr;
      first_wd   = write_data;
      done_at    = 0;
      w          = 1;
      while (done_cnt == base_d && w < 600) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (done_cnt != base_d) done_at = w;
      @(negedge clk);
      #1;
   endtask

   task automatic compare();
      int nx, nr;
      nx = xfer_q.size() - base_x;
      nr = rd_q.size() - base_r;
      check("n_xfer", nx, exp_x.size());
      for (int i = 0; i < nx && i < exp_x.size(); i++) begin
         check("xfer_fs", xfer_q[base_x+i].fs, exp_x[i].fs);
         check("xfer_addr", xfer_q[base_x+i].addr, exp_x[i].addr);
         if (exp_x[i].fs == 2'b10) check("xfer_wdata", xfer_q[base_x+i].wd, exp_x[i].wd);
      end
      check("n_rd", nr, exp_r.size());
      for (int i = 0; i < nr && i < exp_r.size(); i++) begin
         check("rd_index", rd_q[base_r+i].idx, exp_r[i].idx);
         check("rd_data", rd_q[base_r+i].data, exp_r[i].data);
      end
      check("n_done", done_cnt - base_d, 1);
      check("cmd_err", done_err, exp_err);
      if (exp_x.size() > 0) begin
         check("first_fs", first_fs, exp_x[0].fs);
         check("first_addr", first_addr, exp_x[0].addr);
      end else begin
         check("first_fs_idle", first_fs, 2'b00);
         check("done_latency", done_at, 2);
      end
      check("gap_violations", gap_viol, 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_func_start", func_start, 2'b00);
      check("rst_register_addr", register_addr, 8'h00);
      check("rst_write_data", write_data, 8'h00);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_rd_index", rd_index, 5'd0);
      check("rst_cmd_done", cmd_done, 1'b0);
      check("rst_cmd_err", cmd_err, 1'b0);
   endtask

   task automatic timeout_test(input logic [1:0] op, input logic ram, input logic [4:0] r);
      int cyc, w;
      hang = 1'b1;
      wait_ready();
      base_x    = xfer_q.size();
      base_d    = done_cnt;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_ram   = ram;
      cmd_reg   = r;
      cmd_len   = 4'd1;
      cmd_wdata = 8'h3C;
      @(negedge clk);
      #1;
      cmd_valid = 1'b0;
      cyc = 0;
      w   = 0;
      while (done_cnt == base_d && w < 300) begin
         if (func_start != 2'b00) cyc++;
         @(negedge clk);
         #1;
         w++;
      end
      check("fs_cycles", cyc, TB_TO);
      check("n_done", done_cnt - base_d, 1);
      check("cmd_err", done_err, 1'b1);
      check("n_xfer", xfer_q.size() - base_x, 0);
      @(negedge clk);
      #1;
      hang = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_ram   = 1'b0;
      cmd_reg   = 5'd0;
      cmd_len   = 4'd0;
      cmd_wdata = 8'h00;
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(1, 255));

      //          op     ram   reg    len    wdata  nx nr err
      vecs[0]  = '{2'b01, 1'b0, 5'd2,  4'd0,  8'h12, 3, 0, 1'b0};
      vecs[1]  = '{2'b10, 1'b0, 5'd0,  4'd3,  8'h00, 3, 3, 1'b0};
      vecs[2]  = '{2'b10, 1'b0, 5'd29, 4'd4,  8'h00, 2, 2, 1'b1};
      vecs[3]  = '{2'b11, 1'b0, 5'd4,  4'd1,  8'h00, 0, 0, 1'b1};
      vecs[4]  = '{2'b00, 1'b0, 5'd31, 4'd1,  8'h00, 0, 0, 1'b1};
      vecs[5]  = '{2'b01, 1'b0, 5'd7,  4'd0,  8'h80, 1, 0, 1'b0};
      vecs[6]  = '{2'b01, 1'b1, 5'd7,  4'd0,  8'h5A, 3, 0, 1'b0};
      vecs[7]  = '{2'b10, 1'b1, 5'd3,  4'd0,  8'h00, 1, 1, 1'b0};
      vecs[8]  = '{2'b10, 1'b0, 5'd0,  4'd15, 8'h00, 8, 8, 1'b0};
      vecs[9]  = '{2'b10, 1'b1, 5'd30, 4'd1,  8'h00, 1, 1, 1'b0};
      vecs[10] = '{2'b00, 1'b1, 5'd5,  4'd0,  8'h00, 1, 1, 1'b0};
      vecs[11] = '{2'b10, 1'b0, 5'd31, 4'd2,  8'h00, 0, 0, 1'b1};
      vecs[12] = '{2'b01, 1'b0, 5'd31, 4'd0,  8'hA5, 0, 0, 1'b1};
      vecs[13] = '{2'b10, 1'b0, 5'd26, 4'd8,  8'h00, 5, 5, 1'b1};

      repeat (3) @(negedge clk);
      #1;
      cur_tag = "reset";
      check_reset_outputs();
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("ready_after_release", cmd_ready, 1'b1);

      for (int i = 0; i < 14; i++) begin
         cur_tag = $sformatf("vec%0d", i);
         run_cmd(vecs[i].op, vecs[i].ram, vecs[i].r, vecs[i].len, vecs[i].wd);
         build_model(vecs[i].op, vecs[i].ram, vecs[i].r, vecs[i].len, vecs[i].wd);
         compare();
         check("tbl_n_xfer", xfer_q.size() - base_x, vecs[i].n_xfer);
         check("tbl_n_rd", rd_q.size() - base_r, vecs[i].n_rd);
         check("tbl_err", done_err, vecs[i].err);
      end

      // Spurious func_done while idle must be ignored.
      cur_tag = "spurious";
      base_d  = done_cnt;
      base_r  = rd_q.size();
      spur_req++;
      repeat (4) @(negedge clk);
      #1;
      check("no_done", done_cnt - base_d, 0);
      check("no_rd", rd_q.size() - base_r, 0);
      check("still_ready", cmd_ready, 1'b1);

      // Timeouts on a read and on the unprotect step of a write (no protect after).
      cur_tag = "timeout_read";
      timeout_test(2'b00, 1'b0, 5'd3);
      cur_tag = "timeout_write";
      timeout_test(2'b01, 1'b1, 5'd3);
      cur_tag = "after_timeout";
      run_cmd(2'b10, 1'b0, 5'd4, 4'd2, 8'h00);
      build_model(2'b10, 1'b0, 5'd4, 4'd2, 8'h00);
      compare();

      // Asynchronous reset in the middle of a transfer.
      cur_tag = "reset_mid";
      hang = 1'b1;
      wait_ready();
      base_d    = done_cnt;
      base_x    = xfer_q.size();
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      cmd_ram   = 1'b0;
      cmd_reg   = 5'd0;
      cmd_len   = 4'd5;
      @(negedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("fs_active", func_start, 2'b01);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      hang  = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("ready_after", cmd_ready, 1'b1);
      check("no_done_pulse", done_cnt - base_d, 0);
      check("no_xfer", xfer_q.size() - base_x, 0);
      run_cmd(2'b01, 1'b1, 5'd9, 4'd0, 8'hC3);
      build_model(2'b01, 1'b1, 5'd9, 4'd0, 8'hC3);
      compare();

      for (int i = 0; i < 40; i++) begin
         cur_tag = $sformatf("rand%0d", i);
         r_op  = 2'($urandom_range(0, 3));
         r_ram = 1'($urandom_range(0, 1));
         r_reg = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(24, 31))
                                             : 5'($urandom_range(0, 31));
         r_len = 4'($urandom_range(0, 15));
         r_wd  = 8'($urandom);
         run_cmd(r_op, r_ram, r_reg, r_len, r_wd);
         build_model(r_op, r_ram, r_reg, r_len, r_wd);
         compare();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
